// File: rtl/detseq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : detseq_pkg
//  Description : Shared types and constants for the 1100110 detector
//                front-end sequencer: FSM state encoding, active-low
//                7-segment table and hit-count saturation value.
//  Revision    : 1.0 - initial release
// ============================================================================
package detseq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MANUAL    = 2'd1,
        AUTO_RUN  = 2'd2,
        AUTO_DONE = 2'd3
    } state_t;

    // Active-low segments {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] c_seg_table = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    localparam logic [7:0] c_sat   = 8'hFF;
    localparam logic [6:0] c_blank = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Two-flop synchronizer plus stable-level counter for an
//                active-low push key. Emits a one-cycle press pulse when a
//                1->0 level change has been accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // Bring the raw key into the clock domain; idle level is released (1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 1'b1;
            r_cnt   <= '0;
            o_press <= 1'b0;
        end else begin
            o_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                o_press <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/detector_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : detector_sequencer
//  Description : Front-end controller for the 1100110 sequence detector.
//                Debounces the step/start keys, issues manual or automatic
//                step enables with a data bit, and counts detector hits.
//                Optional macro DETSEQ_HEX_EN enables the HEX1/HEX0 decode
//                of the hit count (otherwise the displays are blank).
//  Revision    : 1.0 - initial release
// ============================================================================
module detector_sequencer
    import detseq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STEP_DIV        = 25000000,
    parameter int PATTERN_W       = 10
) (
    input  logic                         CLOCK_50,
    input  logic                         rst,
    input  logic                         shift_n,
    input  logic                         start_n,
    input  logic                         mode,
    input  logic                         x_sw,
    input  logic [PATTERN_W-1:0]         pattern,
    input  logic                         det_hit,
    output logic                         step,
    output logic                         x_out,
    output logic                         busy,
    output logic [$clog2(PATTERN_W)-1:0] pos,
    output logic [7:0]                   match_count,
    output logic [6:0]                   HEX1,
    output logic [6:0]                   HEX0
);

    localparam int               POS_W      = $clog2(PATTERN_W);
    localparam int               DIV_W      = $clog2(STEP_DIV + 1);
    localparam logic [POS_W-1:0] c_pos_init = POS_W'(PATTERN_W - 1);
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(STEP_DIV - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DIV_W-1:0]       r_div;
    logic [PATTERN_W-1:0]   r_pattern_q;
    logic                   r_step_d;
    logic                   w_shift_press;
    logic                   w_start_press;
    logic                   w_tick;
    logic                   w_step_nxt;
    logic                   w_x_nxt;
    logic                   w_enter_auto;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_shift_key (
        .clk     (CLOCK_50),
        .rst     (rst),
        .i_key_n (shift_n),
        .o_press (w_shift_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_key (
        .clk     (CLOCK_50),
        .rst     (rst),
        .i_key_n (start_n),
        .o_press (w_start_press)
    );

    assign w_tick = (r_div == c_div_last);
    assign busy   = (r_state == AUTO_RUN);

    // State register.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and step decisions; a mode change always beats a press.
    always_comb begin
        w_state_nxt  = r_state;
        w_step_nxt   = 1'b0;
        w_x_nxt      = x_out;
        w_enter_auto = 1'b0;
        case (r_state)
            IDLE: begin
                if (!mode) begin
                    w_state_nxt = MANUAL;
                end else if (w_start_press) begin
                    w_state_nxt  = AUTO_RUN;
                    w_enter_auto = 1'b1;
                end
            end
            MANUAL: begin
                if (mode) begin
                    w_state_nxt = IDLE;
                end else if (w_shift_press) begin
                    w_step_nxt = 1'b1;
                    w_x_nxt    = x_sw;
                end
            end
            AUTO_RUN: begin
                if (!mode) begin
                    w_state_nxt = IDLE;
                end else if (w_tick) begin
                    w_step_nxt = 1'b1;
                    w_x_nxt    = r_pattern_q[pos];
                    if (pos == '0) begin
                        w_state_nxt = AUTO_DONE;
                    end
                end
            end
            AUTO_DONE: begin
                if (!mode) begin
                    w_state_nxt = IDLE;
                end else if (w_start_press) begin
                    w_state_nxt  = AUTO_RUN;
                    w_enter_auto = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Step/data registers, step divider and pattern read pointer.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            step        <= 1'b0;
            x_out       <= 1'b0;
            r_step_d    <= 1'b0;
            pos         <= c_pos_init;
            r_div       <= '0;
            r_pattern_q <= '0;
        end else begin
            step     <= w_step_nxt;
            x_out    <= w_x_nxt;
            r_step_d <= step;
            if (w_enter_auto) begin
                r_pattern_q <= pattern;
                pos         <= c_pos_init;
                r_div       <= '0;
            end else if (r_state == AUTO_RUN) begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_step_nxt && (pos != '0)) begin
                    pos <= pos - 1'b1;
                end
            end
        end
    end

    // Hit counter: det_hit is only meaningful the cycle after a step.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            match_count <= '0;
        end else if (w_enter_auto) begin
            match_count <= '0;
        end else if (r_step_d && det_hit && (match_count != c_sat)) begin
            match_count <= match_count + 1'b1;
        end
    end

`ifdef DETSEQ_HEX_EN
    assign HEX1 = c_seg_table[match_count[7:4]];
    assign HEX0 = c_seg_table[match_count[3:0]];
`else
    assign HEX1 = c_blank;
    assign HEX0 = c_blank;
`endif

endmodule
`default_nettype wire

// File: tb/tb_detector_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_detector_sequencer
//  Description : Scoreboard bench for detector_sequencer. Stimulus pushes
//                the expected x_out of every step it provokes; a negedge
//                monitor pops and compares whenever step is high. A small
//                1100110 reference detector drives det_hit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_detector_sequencer;
    import detseq_pkg::*;

    localparam int DEB = 4;
    localparam int DIV = 3;
    localparam int PW  = 10;

`ifdef DETSEQ_HEX_EN
    localparam logic [6:0] c_hex_zero = 7'h40;
    localparam logic [6:0] c_hex_f    = 7'h0E;
`else
    localparam logic [6:0] c_hex_zero = 7'h7F;
    localparam logic [6:0] c_hex_f    = 7'h7F;
`endif

    logic          CLOCK_50 = 1'b0;
    logic          rst      = 1'b1;
    logic          shift_n  = 1'b1;
    logic          start_n  = 1'b1;
    logic          mode     = 1'b0;
    logic          x_sw     = 1'b0;
    logic [PW-1:0] pattern  = '0;
    logic          det_hit;
    logic          step;
    logic          x_out;
    logic          busy;
    logic [3:0]    pos;
    logic [7:0]    match_count;
    logic [6:0]    HEX1;
    logic [6:0]    HEX0;

    logic          force_hit = 1'b0;
    logic          hist_clr  = 1'b1;
    logic [6:0]    hist;

    int checks = 0;
    int errors = 0;
    int step_total = 0;
    int cyc = 0;
    int prev_cyc = 0;
    bit gap_chk = 1'b0;
    bit gap_first = 1'b0;
    bit exp_q[$];

    detector_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .STEP_DIV       (DIV),
        .PATTERN_W      (PW)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .rst         (rst),
        .shift_n     (shift_n),
        .start_n     (start_n),
        .mode        (mode),
        .x_sw        (x_sw),
        .pattern     (pattern),
        .det_hit     (det_hit),
        .step        (step),
        .x_out       (x_out),
        .busy        (busy),
        .pos         (pos),
        .match_count (match_count),
        .HEX1        (HEX1),
        .HEX0        (HEX0)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Reference Moore detector for 1100110 (overlapping).
    always @(posedge CLOCK_50) begin
        if (hist_clr)  hist <= '0;
        else if (step) hist <= {hist[5:0], x_out};
    end
    assign det_hit = force_hit | (hist == 7'b1100110);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge CLOCK_50) begin
        if (!rst && step) begin
            step_total++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_step x_out=%0d exp=none", x_out);
            end else begin
                automatic bit e = exp_q.pop_front();
                if (x_out !== e) begin
                    errors++;
                    $display("FAIL sb_x_out act=%0d exp=%0d", x_out, e);
                end
            end
            if (gap_chk) begin
                if (gap_first) begin
                    gap_first = 1'b0;
                end else begin
                    checks++;
                    if (cyc - prev_cyc != DIV) begin
                        errors++;
                        $display("FAIL step_gap act=%0d exp=%0d", cyc - prev_cyc, DIV);
                    end
                end
            end
            prev_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLOCK_50);
            #1;
        end
    endtask

    task automatic wait_steps(input int target, input int budget);
        int n = 0;
        while (step_total < target && n < budget) begin
            tick(1);
            n++;
        end
        chk("wait_steps_timeout", 32'(step_total >= target), 32'd1);
    endtask

    task automatic press_shift(input int low);
        shift_n = 1'b0;
        tick(low);
        shift_n = 1'b1;
        tick(8);
    endtask

    task automatic push_pattern(input logic [PW-1:0] p, input int n);
        logic [PW-1:0] v = p;
        for (int i = 0; i < n; i++) exp_q.push_back(v[PW-1-i]);
    endtask

    initial begin
        int base;
        // ---------------- reset ----------------
        tick(3);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_match", 32'(match_count), 32'd0);
        chk("rst_pos", 32'(pos), 32'd9);
        chk("rst_hex1", 32'(HEX1), 32'(c_hex_zero));
        chk("rst_hex0", 32'(HEX0), 32'(c_hex_zero));
        rst = 1'b0;
        hist_clr = 1'b0;
        tick(3);

        // ---------------- manual clean press ----------------
        base = step_total;
        x_sw = 1'b1;
        exp_q.push_back(1'b1);
        press_shift(8);
        tick(4);
        chk("man_one_step", 32'(step_total - base), 32'd1);
        chk("man_x_hold", 32'(x_out), 32'd1);
        x_sw = 1'b0;
        exp_q.push_back(1'b0);
        press_shift(8);
        chk("man_second_step", 32'(step_total - base), 32'd2);

        // ---------------- bounced key: 3-cycle glitches ----------------
        base = step_total;
        for (int i = 0; i < 3; i++) begin
            shift_n = 1'b0;
            tick(3);
            shift_n = 1'b1;
            tick(3);
        end
        tick(10);
        chk("glitch_no_step", 32'(step_total - base), 32'd0);

        // ---------------- auto run ----------------
        hist_clr = 1'b1;
        tick(1);
        hist_clr = 1'b0;
        pattern = 10'b0001100110;
        mode = 1'b1;
        tick(2);
        base = step_total;
        push_pattern(10'b0001100110, 10);
        gap_first = 1'b1;
        gap_chk = 1'b1;
        start_n = 1'b0;
        tick(6);
        start_n = 1'b1;
        wait_steps(base + 10, 200);
        tick(8);
        gap_chk = 1'b0;
        chk("auto_steps", 32'(step_total - base), 32'd10);
        chk("auto_match", 32'(match_count), 32'd1);
        chk("auto_busy", 32'(busy), 32'd0);
        chk("auto_state", 32'(dut.r_state), 32'(AUTO_DONE));

        // ---------------- abort after 4th step ----------------
        force_hit = 1'b1;
        pattern = 10'b1011000000;
        base = step_total;
        push_pattern(10'b1011000000, 4);
        start_n = 1'b0;
        tick(6);
        start_n = 1'b1;
        wait_steps(base + 4, 100);
        mode = 1'b0;
        tick(1);
        chk("abort_idle", 32'(dut.r_state), 32'(IDLE));
        tick(1);
        chk("abort_manual", 32'(dut.r_state), 32'(MANUAL));
        tick(10);
        chk("abort_steps", 32'(step_total - base), 32'd4);
        chk("abort_match", 32'(match_count), 32'd4);

        // ---------------- saturation ----------------
        for (int i = 0; i < 300; i++) begin
            x_sw = i[0];
            exp_q.push_back(i[0]);
            press_shift(6);
        end
        tick(3);
        chk("sat_match", 32'(match_count), 32'hFF);
        chk("sat_hex1", 32'(HEX1), 32'(c_hex_f));
        chk("sat_hex0", 32'(HEX0), 32'(c_hex_f));

        // ---------------- reset mid-run ----------------
        pattern = 10'b1111111111;
        mode = 1'b1;
        tick(2);
        base = step_total;
        push_pattern(10'b1111111111, 4);
        start_n = 1'b0;
        tick(6);
        start_n = 1'b1;
        wait_steps(base + 4, 100);
        chk("mid_pos", 32'(pos), 32'd5);
        tick(2);
        chk("mid_pre_match", 32'(match_count), 32'd4);
        chk("mid_pre_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_state", 32'(dut.r_state), 32'(IDLE));
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_step", 32'(step), 32'd0);
        chk("mid_rst_match", 32'(match_count), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(20);
        chk("mid_no_step", 32'(step_total - base), 32'd4);
        exp_q.push_back(1'b1);
        start_n = 1'b0;
        tick(6);
        start_n = 1'b1;
        wait_steps(base + 5, 60);
        mode = 1'b0;
        tick(8);
        chk("mid_restart_steps", 32'(step_total - base), 32'd5);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
